wam_round_controller: RTL and testbench
=======================================

WAM_ROUND_CONTROLLER -- requirements
Module: wam_round_controller

Interface
REQ-001 N_LIGHTS, 9, number of lights/keys; legal range 2..16.
REQ-002 TICK, 50_000_000, clk cycles per second; benches override it with a small value.
REQ-003 LEVEL_STEP, 5, hits per level advance in continuity mode.
REQ-004 clk  in  1  system clock; all logic is on the rising edge.
REQ-005 reset  in  1  reset; one clock; reset is synchronous and active-low.
REQ-006 play  in  1  debounced one-cycle pulse; starts, aborts or restarts a game.
REQ-007 mode  in  4  one-hot: 0001 normal, 0010 timed, 0100 deathmatch, 1000 continuity.
REQ-008 difficulty  in  4  one-hot level select 1..4.
REQ-009 extended  in  1  0 selects max_hits 25; 1 selects max_hits 50.
REQ-010 seed  in  8  LFSR seed.
REQ-011 key_valid  in  1  one-cycle pulse when key holds a new press.
REQ-012 key  in  4  pressed key index.
REQ-013 light_en  out  1  the light at light_pos is lit.
REQ-014 light_pos  out  4  current light index, 0..N_LIGHTS-1.
REQ-015 score  out  7  hits, saturating at 99.
REQ-016 flicks  out  7  lights lit this game.
REQ-017 max_hits  out  7  25 or 50.
REQ-018 time_left  out  6  seconds remaining; timed mode only, else 0.
REQ-019 level  out  3  active level, 1..4.
REQ-020 game_over  out  1  high in OVER.
REQ-021 state  out  2  IDLE=0, GAP=1, LIT=2, OVER=3.

Function
REQ-022 FSM states: IDLE, GAP, LIT, OVER.
- IDLE -play-> GAP.
- GAP -gap timer done-> LIT.
- LIT -hit or on-timer done-> GAP, or -> OVER when an end condition is met.
- GAP/LIT -play-> OVER (abort).
- OVER -play-> GAP (restart).
REQ-023 Game start, from IDLE or from OVER:
- clears score, flicks and the timers;
- sets time_left=60 in timed mode;
- sets level to the difficulty level, or to 1 in continuity mode.
REQ-024 Level timing (gap/on):
- L1: 2*TICK / 2*TICK
- L2: TICK / TICK
- L3: TICK/2 / TICK
- L4: TICK/4 / TICK/2
- A non-one-hot difficulty selects L2.
- Timers count from 0 to value-1.
REQ-025 mode and difficulty are sampled only at game start; extended is sampled at game start and drives max_hits; a non-one-hot mode is treated as normal.
REQ-026 On GAP->LIT:
- light_pos = LFSR value mod N_LIGHTS;
- if that equals the previous light_pos, light_pos = (value+1) mod N_LIGHTS;
- flicks increments.
REQ-027 LFSR: 8-bit Fibonacci, taps 8,6,5,4; it advances every cycle; at game start from IDLE it loads seed, with seed 0 replaced by 8'h01; restart from OVER does not reload it.
REQ-028 Hit: in LIT, key_valid with key==light_pos; score+1 (saturating at 99), light_en drops next cycle, go to GAP.
REQ-029 Wrong key in LIT, or any key in GAP:
- deathmatch: go to OVER;
- other modes: ignored.
REQ-030 Miss (on-timer expires in LIT): deathmatch -> OVER; other modes -> GAP.
REQ-031 When key_valid coincides with on-timer expiry, the cycle counts as a hit.
REQ-032 End conditions:
- normal, continuity: the light that makes flicks==max_hits resolves (hit or miss) -> OVER;
- timed: time_left reaches 0 -> OVER, with no flick limit.
REQ-033 In timed mode, time_left decrements once per TICK cycles while in GAP/LIT; a decrement to 0 wins over any other event in that cycle.
REQ-034 Continuity: level increments after every LEVEL_STEP hits, saturating at 4; the new timing applies from the next GAP.
REQ-035 In OVER: light_en=0; score, flicks, level and time_left hold; play has priority over key_valid.

Reset
REQ-036 reset=0 at the next edge sets:
- state=IDLE, light_en=0, light_pos=0;
- score=0, flicks=0, time_left=0, level=1, game_over=0;
- timers cleared, LFSR=8'h01.
It acts from any state, including mid-game.
REQ-037 reset has priority over play and key_valid in the same cycle.

Structure
REQ-038 Package wam_pkg holds:
- state encodings;
- mode one-hot constants;
- max hit constants 25/50;
- level timing divisors.
REQ-039 The LFSR is a sub-module, wam_lfsr (load, seed, value).

Verification
REQ-040 All scenarios use TICK=8.
REQ-041 Reset, then play with L2 normal: GAP for 8 cycles, then light_en=1 with flicks=1.
REQ-042 Normal, extended=0:
- every light is hit within its on-time, giving score=25, flicks=25, state OVER;
- a further key_valid leaves score at 25.
REQ-043 Deathmatch:
- a wrong key in LIT gives OVER, score unchanged;
- a separate run lets the on-timer expire, giving OVER.
REQ-044 Timed: no keys pressed:
- time_left goes 60->0 over 480 cycles in GAP/LIT;
- game_over=1 on reaching 0.
REQ-045 A key hit on the exact on-timer expiry cycle counts as a hit (score+1); play in OVER restarts with score=0, flicks=0.
REQ-046 Continuity: after 5 hits level=2 and the next gap is 8 cycles; reset=0 mid-LIT returns IDLE, light_en=0.

Source files
------------

// File: rtl/wam_pkg.sv
// rtl/wam_pkg.sv - shared encodings, constants and level timing for the whack-a-mole round controller
package wam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_LIT  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  localparam logic [3:0] MODE_NORMAL = 4'b0001;
  localparam logic [3:0] MODE_TIMED  = 4'b0010;
  localparam logic [3:0] MODE_DEATH  = 4'b0100;
  localparam logic [3:0] MODE_CONT   = 4'b1000;

  localparam logic [6:0] HITS_STD   = 7'd25;
  localparam logic [6:0] HITS_EXT   = 7'd50;
  localparam logic [6:0] SCORE_MAX  = 7'd99;
  localparam logic [6:0] FLICKS_MAX = 7'd127;
  localparam logic [5:0] TIME_START = 6'd60;

  // Phase lengths in quarter seconds, indexed by level (gap / on).
  localparam logic [3:0] L1_GAP_QTR = 4'd8, L1_ON_QTR = 4'd8;
  localparam logic [3:0] L2_GAP_QTR = 4'd4, L2_ON_QTR = 4'd4;
  localparam logic [3:0] L3_GAP_QTR = 4'd2, L3_ON_QTR = 4'd4;
  localparam logic [3:0] L4_GAP_QTR = 4'd1, L4_ON_QTR = 4'd2;

  function automatic logic [31:0] phase_len(input logic [2:0] lvl, input logic lit,
                                            input logic [31:0] tick);
    logic [3:0] qtr;
    case (lvl)
      3'd1:    qtr = lit ? L1_ON_QTR : L1_GAP_QTR;
      3'd2:    qtr = lit ? L2_ON_QTR : L2_GAP_QTR;
      3'd3:    qtr = lit ? L3_ON_QTR : L3_GAP_QTR;
      default: qtr = lit ? L4_ON_QTR : L4_GAP_QTR;
    endcase
    return ({28'd0, qtr} * tick) / 32'd4;
  endfunction

  function automatic logic [3:0] norm_mode(input logic [3:0] m);
    case (m)
      MODE_NORMAL, MODE_TIMED, MODE_DEATH, MODE_CONT: return m;
      default: return MODE_NORMAL;
    endcase
  endfunction

  function automatic logic [2:0] diff_level(input logic [3:0] d);
    case (d)
      4'b0001: return 3'd1;
      4'b0010: return 3'd2;
      4'b0100: return 3'd3;
      4'b1000: return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/wam_lfsr.sv
// rtl/wam_lfsr.sv - free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) with seed load
module wam_lfsr (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] value_q, value_d;

  always_comb begin
    value_d = {value_q[6:0], value_q[7] ^ value_q[5] ^ value_q[4] ^ value_q[3]};
    // An all-zero state would lock the register, so a zero seed becomes 1.
    if (load) value_d = (seed == 8'h00) ? 8'h01 : seed;
  end

  always_ff @(posedge clk) begin
    if (!reset) value_q <= 8'h01;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/wam_round_controller.sv
// rtl/wam_round_controller.sv - game round FSM: light timing, scoring, levels and end conditions
module wam_round_controller
  import wam_pkg::*;
#(
  parameter int N_LIGHTS   = 9,
  parameter int TICK       = 50_000_000,
  parameter int LEVEL_STEP = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic [3:0] mode,
  input  logic [3:0] difficulty,
  input  logic       extended,
  input  logic [7:0] seed,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic       light_en,
  output logic [3:0] light_pos,
  output logic [6:0] score,
  output logic [6:0] flicks,
  output logic [6:0] max_hits,
  output logic [5:0] time_left,
  output logic [2:0] level,
  output logic       game_over,
  output logic [1:0] state
);

  state_e      state_q, state_d;
  logic [31:0] tmr_q, tmr_d, sec_q, sec_d, gap_len, on_len;
  logic [6:0]  score_q, score_d, flicks_q, flicks_d, max_hits_q, max_hits_d, step_q, step_d;
  logic [5:0]  time_left_q, time_left_d;
  logic [2:0]  level_q, level_d;
  logic [3:0]  mode_q, mode_d, light_pos_q, light_pos_d, new_mode, pos_a, pos_b;
  logic [7:0]  lfsr_val;
  logic        lfsr_load, timed, death, limit, sec_wrap, timeout, hit, level_up;

  assign lfsr_load = (state_q == ST_IDLE) && play;

  wam_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (seed),
    .value (lfsr_val)
  );

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    sec_d       = sec_q;
    score_d     = score_q;
    flicks_d    = flicks_q;
    max_hits_d  = max_hits_q;
    step_d      = step_q;
    time_left_d = time_left_q;
    level_d     = level_q;
    mode_d      = mode_q;
    light_pos_d = light_pos_q;
    new_mode    = norm_mode(mode);
    timed       = (mode_q == MODE_TIMED);
    death       = (mode_q == MODE_DEATH);
    limit       = ((mode_q == MODE_NORMAL) || (mode_q == MODE_CONT)) && (flicks_q == max_hits_q);
    sec_wrap    = timed && (sec_q == 32'(TICK - 1));
    timeout     = sec_wrap && (time_left_q == 6'd1);
    hit         = key_valid && (key == light_pos_q);
    level_up    = (step_q == 7'(LEVEL_STEP - 1));
    gap_len     = phase_len(level_q, 1'b0, 32'(TICK));
    on_len      = phase_len(level_q, 1'b1, 32'(TICK));
    pos_a       = 4'({1'b0, lfsr_val} % 9'(N_LIGHTS));
    pos_b       = 4'(({1'b0, lfsr_val} + 9'd1) % 9'(N_LIGHTS));

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (play) begin
          state_d     = ST_GAP;
          tmr_d       = '0;
          sec_d       = '0;
          score_d     = '0;
          flicks_d    = '0;
          step_d      = '0;
          mode_d      = new_mode;
          max_hits_d  = extended ? HITS_EXT : HITS_STD;
          time_left_d = (new_mode == MODE_TIMED) ? TIME_START : 6'd0;
          level_d     = (new_mode == MODE_CONT) ? 3'd1 : diff_level(difficulty);
        end
      end
      default: begin
        if (play) begin
          state_d = ST_OVER;
        end else begin
          tmr_d = tmr_q + 32'd1;
          if (timed) begin
            sec_d = sec_wrap ? 32'd0 : sec_q + 32'd1;
            if (sec_wrap) time_left_d = time_left_q - 6'd1;
          end
          // The final second ends the game regardless of what else happens this cycle.
          if (timeout) begin
            state_d = ST_OVER;
          end else if (state_q == ST_GAP) begin
            if (key_valid && death) begin
              state_d = ST_OVER;
            end else if (tmr_q == gap_len - 32'd1) begin
              state_d     = ST_LIT;
              tmr_d       = '0;
              light_pos_d = (pos_a == light_pos_q) ? pos_b : pos_a;
              if (flicks_q != FLICKS_MAX) flicks_d = flicks_q + 7'd1;
            end
          end else if (hit) begin
            if (score_q != SCORE_MAX) score_d = score_q + 7'd1;
            if (mode_q == MODE_CONT) begin
              step_d = level_up ? 7'd0 : step_q + 7'd1;
              if (level_up && (level_q != 3'd4)) level_d = level_q + 3'd1;
            end
            state_d = limit ? ST_OVER : ST_GAP;
            tmr_d   = '0;
          end else if (key_valid && death) begin
            state_d = ST_OVER;
          end else if (tmr_q == on_len - 32'd1) begin
            state_d = (death || limit) ? ST_OVER : ST_GAP;
            tmr_d   = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      sec_q       <= '0;
      score_q     <= '0;
      flicks_q    <= '0;
      max_hits_q  <= HITS_STD;
      step_q      <= '0;
      time_left_q <= '0;
      level_q     <= 3'd1;
      mode_q      <= MODE_NORMAL;
      light_pos_q <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      sec_q       <= sec_d;
      score_q     <= score_d;
      flicks_q    <= flicks_d;
      max_hits_q  <= max_hits_d;
      step_q      <= step_d;
      time_left_q <= time_left_d;
      level_q     <= level_d;
      mode_q      <= mode_d;
      light_pos_q <= light_pos_d;
    end
  end

  assign light_en  = (state_q == ST_LIT);
  assign game_over = (state_q == ST_OVER);
  assign state     = state_q;
  assign light_pos = light_pos_q;
  assign score     = score_q;
  assign flicks    = flicks_q;
  assign max_hits  = max_hits_q;
  assign time_left = time_left_q;
  assign level     = level_q;

endmodule

// File: tb/tb_wam_round_controller.sv
// tb/tb_wam_round_controller.sv - randomized and directed self-checking bench against a game-rule model
module tb_wam_round_controller;

  localparam int NL = 9;
  localparam int TK = 8;
  localparam int LS = 5;

  logic       clk = 1'b0;
  logic       reset, play, extended, key_valid;
  logic [3:0] mode, difficulty, key;
  logic [7:0] seed;
  logic       light_en, game_over;
  logic [3:0] light_pos;
  logic [6:0] score, flicks, max_hits;
  logic [5:0] time_left;
  logic [2:0] level;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_state, m_pos, m_score, m_flicks, m_max, m_time, m_level, m_lfsr;
  int m_elapsed, m_play_cyc, m_hits, m_mode;
  int gap_cyc[5] = '{0, 2 * TK, TK, TK / 2, TK / 4};
  int on_cyc[5]  = '{0, 2 * TK, TK, TK, TK / 2};

  wam_round_controller #(.N_LIGHTS(NL), .TICK(TK), .LEVEL_STEP(LS)) dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .mode       (mode),
    .difficulty (difficulty),
    .extended   (extended),
    .seed       (seed),
    .key_valid  (key_valid),
    .key        (key),
    .light_en   (light_en),
    .light_pos  (light_pos),
    .score      (score),
    .flicks     (flicks),
    .max_hits   (max_hits),
    .time_left  (time_left),
    .level      (level),
    .game_over  (game_over),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lvl_of(input int d);
    if (d == 1) return 1;
    if (d == 2) return 2;
    if (d == 4) return 3;
    if (d == 8) return 4;
    return 2;
  endfunction

  // Game rules applied to one rising edge, using the inputs present at that edge.
  task automatic model_step();
    int  nxt_lfsr, cand;
    bit  dm, limited, timeout;
    nxt_lfsr = ((m_lfsr << 1) & 255) |
               (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
    if (!reset) begin
      m_state = 0; m_pos = 0; m_score = 0; m_flicks = 0; m_time = 0; m_level = 1;
      m_lfsr = 1; m_elapsed = 0; m_play_cyc = 0; m_hits = 0; m_max = 25; m_mode = 1;
      return;
    end
    if (m_state == 0 || m_state == 3) begin
      if (play) begin
        if (m_state == 0) nxt_lfsr = (seed == 8'd0) ? 1 : int'(seed);
        m_mode = (int'(mode) inside {1, 2, 4, 8}) ? int'(mode) : 1;
        m_state = 1; m_score = 0; m_flicks = 0; m_elapsed = 0; m_play_cyc = 0; m_hits = 0;
        m_max   = extended ? 50 : 25;
        m_time  = (m_mode == 2) ? 60 : 0;
        m_level = (m_mode == 8) ? 1 : lvl_of(int'(difficulty));
      end
    end else if (play) begin
      m_state = 3;
    end else begin
      dm      = (m_mode == 4);
      limited = (m_mode == 1 || m_mode == 8) && (m_flicks == m_max);
      timeout = 1'b0;
      m_elapsed++;
      if (m_mode == 2) begin
        m_play_cyc++;
        if (m_play_cyc % TK == 0) begin
          m_time--;
          timeout = (m_time == 0);
        end
      end
      if (timeout) begin
        m_state = 3;
      end else if (m_state == 1) begin
        if (key_valid && dm) m_state = 3;
        else if (m_elapsed == gap_cyc[m_level]) begin
          cand  = m_lfsr % NL;
          m_pos = (cand == m_pos) ? (m_lfsr + 1) % NL : cand;
          if (m_flicks < 127) m_flicks++;
          m_state = 2; m_elapsed = 0;
        end
      end else if (key_valid && int'(key) == m_pos) begin
        if (m_score < 99) m_score++;
        if (m_mode == 8) begin
          m_hits++;
          if (m_hits % LS == 0 && m_level < 4) m_level++;
        end
        m_state = limited ? 3 : 1; m_elapsed = 0;
      end else if (key_valid && dm) begin
        m_state = 3;
      end else if (m_elapsed == on_cyc[m_level]) begin
        m_state = (dm || limited) ? 3 : 1; m_elapsed = 0;
      end
    end
    m_lfsr = nxt_lfsr;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(state), m_state);
      chk("light_en", int'(light_en), (m_state == 2) ? 1 : 0);
      chk("game_over", int'(game_over), (m_state == 3) ? 1 : 0);
      chk("light_pos", int'(light_pos), m_pos);
      chk("score", int'(score), m_score);
      chk("flicks", int'(flicks), m_flicks);
      chk("max_hits", int'(max_hits), m_max);
      chk("time_left", int'(time_left), m_time);
      chk("level", int'(level), m_level);
    end
  end

  task automatic cycle(input bit p, input bit kv, input logic [3:0] k);
    play = p; key_valid = kv; key = k;
    @(posedge clk);
    model_step();
    @(negedge clk);
    play = 1'b0; key_valid = 1'b0;
  endtask

  task automatic wait_lit(input int bound);
    int n;
    n = 0;
    while (light_en !== 1'b1 && n < bound) begin
      cycle(1'b0, 1'b0, 4'd0);
      n++;
    end
    chk("wait_lit", int'(light_en), 1);
  endtask

  initial begin
    int n;
    reset = 1'b0; play = 1'b0; key_valid = 1'b0; key = 4'd0;
    mode = 4'b0001; difficulty = 4'b0010; extended = 1'b0; seed = 8'h5A;
    cycle(1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b0, 4'd0);
    chk_en = 1'b1;
    chk("rst_state", int'(state), 0);
    chk("rst_light_en", int'(light_en), 0);
    chk("rst_level", int'(level), 1);
    chk("rst_score", int'(score), 0);
    reset = 1'b1;

    // Normal L2: 8-cycle gap, then first light
    cycle(1'b1, 1'b0, 4'd0);
    n = 0;
    while (light_en !== 1'b1 && n < 100) begin cycle(1'b0, 1'b0, 4'd0); n++; end
    chk("first_gap_len", n, 8);
    chk("first_flicks", int'(flicks), 1);

    // Hit every light until the 25-flick limit
    n = 0;
    while (game_over !== 1'b1 && n < 40) begin
      wait_lit(100);
      cycle(1'b0, 1'b1, 4'(m_pos));
      n++;
    end
    chk("norm_score", int'(score), 25);
    chk("norm_flicks", int'(flicks), 25);
    chk("norm_state", int'(state), 3);
    cycle(1'b0, 1'b1, 4'(m_pos));
    chk("over_key_score", int'(score), 25);

    // Deathmatch: wrong key, then on-timer expiry
    mode = 4'b0100;
    cycle(1'b1, 1'b0, 4'd0);
    wait_lit(100);
    cycle(1'b0, 1'b1, 4'((m_pos + 1) % NL));
    chk("dm_wrong_state", int'(state), 3);
    chk("dm_wrong_score", int'(score), 0);
    cycle(1'b1, 1'b0, 4'd0);
    wait_lit(100);
    n = 0;
    while (game_over !== 1'b1 && n < 100) begin cycle(1'b0, 1'b0, 4'd0); n++; end
    chk("dm_miss_cycles", n, 8);
    chk("dm_miss_flicks", int'(flicks), 1);

    // Timed: 60 seconds of 8 cycles each with no keys
    mode = 4'b0010;
    cycle(1'b1, 1'b0, 4'd0);
    chk("timed_start", int'(time_left), 60);
    n = 0;
    while (game_over !== 1'b1 && n < 600) begin
      cycle(1'b0, 1'b0, 4'd0);
      n++;
      if (n == 8) chk("timed_first_sec", int'(time_left), 59);
    end
    chk("timed_cycles", n, 480);
    chk("timed_end", int'(time_left), 0);

    // Hit on the exact expiry cycle, then abort and restart
    mode = 4'b0001;
    cycle(1'b1, 1'b0, 4'd0);
    wait_lit(100);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b1, 4'(m_pos));
    chk("expiry_hit_score", int'(score), 1);
    chk("expiry_hit_state", int'(state), 1);
    cycle(1'b1, 1'b0, 4'd0);
    chk("abort_state", int'(state), 3);
    cycle(1'b1, 1'b0, 4'd0);
    chk("restart_score", int'(score), 0);
    chk("restart_flicks", int'(flicks), 0);

    // Continuity: five hits raise the level, then reset mid-LIT
    cycle(1'b1, 1'b0, 4'd0);
    mode = 4'b1000;
    cycle(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      wait_lit(100);
      cycle(1'b0, 1'b1, 4'(m_pos));
    end
    chk("cont_level", int'(level), 2);
    n = 0;
    while (light_en !== 1'b1 && n < 100) begin cycle(1'b0, 1'b0, 4'd0); n++; end
    chk("cont_gap_len", n, 8);
    reset = 1'b0;
    cycle(1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    chk("midlit_rst_state", int'(state), 0);
    chk("midlit_rst_light", int'(light_en), 0);

    // Random play against the model
    for (int g = 0; g < 3200; g++) begin
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 4))
          0: mode = 4'b0001;
          1: mode = 4'b0010;
          2: mode = 4'b0100;
          3: mode = 4'b1000;
          default: mode = 4'($urandom);
        endcase
        difficulty = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
        extended = 1'($urandom);
        seed = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      end
      reset = ($urandom_range(0, 599) != 0);
      cycle(((m_state == 0 || m_state == 3) && $urandom_range(0, 9) == 0) ||
            ($urandom_range(0, 299) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 0) ? 4'(m_pos) : 4'($urandom));
    end
    reset = 1'b1;

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=%0d required=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
